// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              req_bad;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_error  = resp_error_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wd      = mem_wd_q;
    assign mem_wr      = mem_wr_q;

    // Illegal size, or halfword/word not naturally aligned
    assign req_bad = (req_size == 2'd3)
                  || ((req_size == 2'd1) && req_addr[0])
                  || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // Lane extraction with sign/zero extension for loads
    always_comb begin
        byte_sel = mem_rd[{lane_q, 3'b000} +: 8];
        half_sel = mem_rd[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rd;
        endcase
    end

    // Sub-word store data replaces its own lane; the other lanes come from memory
    always_comb begin
        merged = mem_rd;
        if (size_q == 2'd0) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Next-state and registered-output logic; outputs are computed one state ahead
    always_comb begin
        state_d       = state_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        mem_address_d = mem_address_q;
        mem_wd_d      = mem_wd_q;
        mem_wr_d      = 1'b0;
        resp_valid_d  = 1'b0;
        resp_error_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d        = req_size;
                    signed_d      = req_signed;
                    lane_d        = req_addr[1:0];
                    wdata_d       = req_wdata[15:0];
                    mem_address_d = {req_addr[ADDR_W-1:2], 2'b00};
                    resp_rdata_d  = '0;
                    if (req_bad) begin
                        state_d      = S_ERR;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'd2) begin
                        state_d  = S_WRITE;
                        mem_wr_d = 1'b1;
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                resp_rdata_d = load_val;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                mem_wd_d = merged;
                mem_wr_d = 1'b1;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            lane_q        <= 2'd0;
            wdata_q       <= '0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            mem_wr_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            mem_address_q <= mem_address_d;
            mem_wd_q      <= mem_wd_d;
            mem_wr_q      <= mem_wr_d;
            resp_valid_q  <= resp_valid_d;
            resp_error_q  <= resp_error_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wd;
    logic        mem_wr;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wrs;
        int          wr_cyc;
        logic [31:0] wd;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total    = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .mem_address (mem_address),
        .mem_wd      (mem_wd),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rd = mem[mem_address[11:2]];

    always @(posedge clock) begin
        if (mem_wr) mem[mem_address[11:2]] <= mem_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input int wrs, input int wr_cyc, input logic [31:0] wd,
                                input logic [31:0] addr);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.wrs = wrs;
        e.wr_cyc = wr_cyc; e.wd = wd; e.addr = addr;
        return e;
    endfunction

    // Follows one accepted request to its response and compares against the scoreboard head
    task automatic wait_resp(input string tag);
        int          lat = 0;
        int          wrs = 0;
        int          wr_cyc = 0;
        logic [31:0] wd_seen = '0;
        logic [31:0] addr_seen = '0;
        logic [31:0] rdata_seen = '0;
        logic        err_seen = 1'b0;
        logic        got = 1'b0;
        exp_t        e;
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            if (mem_wr) begin
                wrs++;
                wr_cyc    = lat;
                wd_seen   = mem_wd;
                addr_seen = mem_address;
            end
            if (resp_valid) begin
                got        = 1'b1;
                rdata_seen = resp_rdata;
                err_seen   = resp_error;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rdata_seen, e.rdata);
            check({tag, "_error"}, 32'(err_seen), 32'(e.err));
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            check({tag, "_wr_cycles"}, 32'(wrs), 32'(e.wrs));
            if (e.wrs > 0) begin
                check({tag, "_wr_at"}, 32'(wr_cyc), 32'(e.wr_cyc));
                check({tag, "_wd"}, wd_seen, e.wd);
                check({tag, "_wr_addr"}, addr_seen, e.addr);
            end
        end
        @(negedge clock);
        check({tag, "_pulse_one"}, 32'(resp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        @(negedge clock);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        sb.push_back(e);
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_wdata  = 32'h0BAD_0BAD;
        wait_resp(tag);
    endtask

    initial begin
        exp_t e;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        #12;
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);

        // Word store then word load
        do_req("st_w100", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF,
               mk(32'h0, 1'b0, 2, 1, 1, 32'hDEAD_BEEF, 32'h100));
        do_req("ld_w100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,
               mk(32'hDEAD_BEEF, 1'b0, 2, 0, 0, 32'h0, 32'h0));

        // Sub-word loads with extension
        do_req("ld_sb103", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0,
               mk(32'hFFFF_FFDE, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        do_req("ld_ub101", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0,
               mk(32'h0000_00BE, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        do_req("ld_sh102", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0,
               mk(32'hFFFF_DEAD, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        do_req("ld_uh100", 1'b0, 2'd1, 1'b0, 32'h100, 32'h0,
               mk(32'h0000_BEEF, 1'b0, 2, 0, 0, 32'h0, 32'h0));

        // Byte store read-modify-write
        do_req("st_w200", 1'b1, 2'd2, 1'b0, 32'h200, 32'h1122_3344,
               mk(32'h0, 1'b0, 2, 1, 1, 32'h1122_3344, 32'h200));
        do_req("st_b201", 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00AA,
               mk(32'h0, 1'b0, 3, 1, 2, 32'h1122_AA44, 32'h200));
        do_req("ld_w200", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0,
               mk(32'h1122_AA44, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        do_req("st_h202", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_5566,
               mk(32'h0, 1'b0, 3, 1, 2, 32'h5566_AA44, 32'h200));

        // Misaligned and illegal accesses
        do_req("err_w102", 1'b1, 2'd2, 1'b0, 32'h102, 32'h1234_5678,
               mk(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0));
        do_req("err_h103", 1'b0, 2'd1, 1'b1, 32'h103, 32'h0,
               mk(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0));
        do_req("err_sz3", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0,
               mk(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0));
        do_req("ld_w102_chk", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,
               mk(32'hDEAD_BEEF, 1'b0, 2, 0, 0, 32'h0, 32'h0));

        // Reset during RMW_RD of a byte store
        do_req("st_w300", 1'b1, 2'd2, 1'b0, 32'h300, 32'h5566_7788,
               mk(32'h0, 1'b0, 2, 1, 1, 32'h5566_7788, 32'h300));
        @(negedge clock);
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h300; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("rmwrst_wr_in_rd", 32'(mem_wr), 32'd0);
        check("rmwrst_busy", 32'(req_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rmwrst_wr_async", 32'(mem_wr), 32'd0);
        check("rmwrst_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("rmwrst_wr_hold", 32'(mem_wr), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rmwrst_ready", 32'(req_ready), 32'd1);
        check("rmwrst_no_resp2", 32'(resp_valid), 32'd0);
        check("rmwrst_wr_after", 32'(mem_wr), 32'd0);
        check("rmwrst_mem", mem[32'h300 >> 2], 32'h5566_7788);
        do_req("ld_w300", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0,
               mk(32'h5566_7788, 1'b0, 2, 0, 0, 32'h0, 32'h0));

        // Held request: second load only accepted in the IDLE cycle after the first RESP
        @(negedge clock);
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h100; req_valid = 1'b1;
        check("held_ready0", 32'(req_ready), 32'd1);
        sb.push_back(mk(32'hDEAD_BEEF, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        sb.push_back(mk(32'h5566_AA44, 1'b0, 2, 0, 0, 32'h0, 32'h0));
        @(negedge clock);
        req_addr = 32'h200;
        check("held_busy_c1", 32'(req_ready), 32'd0);
        check("held_noresp_c1", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("held_busy_c2", 32'(req_ready), 32'd0);
        check("held_resp_c2", 32'(resp_valid), 32'd1);
        e = sb.pop_front();
        check("held_rdata_a", resp_rdata, e.rdata);
        @(negedge clock);
        check("held_idle_c3", 32'(req_ready), 32'd1);
        check("held_noresp_c3", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("held_busy_c4", 32'(req_ready), 32'd0);
        check("held_noresp_c4", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("held_resp_c5", 32'(resp_valid), 32'd1);
        e = sb.pop_front();
        check("held_rdata_b", resp_rdata, e.rdata);
        check("held_err_b", 32'(resp_error), 32'(e.err));
        @(negedge clock);
        check("held_idle_c6", 32'(req_ready), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
